gan_batch_sched: RTL and testbench

GAN_BATCH_SCHED -- requirements
Module: gan_batch_sched

---
 rtl/gan_batch_sched.sv | 119 +++++++++++
 tb/tb_gan_batch_sched.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gan_batch_sched.sv
// gan_batch_sched: queues noise pairs and runs them one at a time through a GAN engine,
// returning each discriminator verdict (or a timeout) over a ready/valid result port.
module gan_batch_sched #(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [15:0]                 in_noise0,
    input  logic [15:0]                 in_noise1,
    output logic                        eng_start,
    output logic [15:0]                 eng_noise0,
    output logic [15:0]                 eng_noise1,
    input  logic                        eng_done,
    input  logic [15:0]                 eng_prob,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [15:0]                 out_prob,
    output logic                        out_real,
    output logic                        out_timeout,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

    state_t          state_q, state_d;
    logic [31:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic [15:0]     n0_q, n1_q, prob_q, prob_d;
    logic            real_q, real_d, tmo_q, tmo_d;
    logic            push, pop;

    assign in_ready    = count_q < CW'(FIFO_DEPTH);
    assign push        = in_valid && in_ready;
    // The head is popped on the edge entering LAUNCH so operands are valid alongside eng_start.
    assign pop         = (state_q == IDLE) && (count_q != '0);
    assign count_d     = count_q + CW'(push) - CW'(pop);
    assign eng_start   = state_q == LAUNCH;
    assign out_valid   = state_q == HOLD;
    assign busy        = state_q != IDLE;
    assign count       = count_q;
    assign eng_noise0  = n0_q;
    assign eng_noise1  = n1_q;
    assign out_prob    = prob_q;
    assign out_real    = real_q;
    assign out_timeout = tmo_q;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        prob_d  = prob_q;
        real_d  = real_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            IDLE:   state_d = (count_q != '0) ? LAUNCH : IDLE;
            LAUNCH: begin
                tmr_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    prob_d  = eng_prob;
                    real_d  = $signed(eng_prob) > 16'sh4000;
                    tmo_d   = 1'b0;
                    state_d = HOLD;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                    if (tmr_q == TW'(TIMEOUT_CYC - 1)) begin
                        prob_d  = '0;
                        real_d  = 1'b0;
                        tmo_d   = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD:   state_d = out_ready ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tmr_q    <= '0;
            n0_q     <= '0;
            n1_q     <= '0;
            prob_q   <= '0;
            real_q   <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            tmr_q    <= tmr_d;
            prob_q   <= prob_d;
            real_q   <= real_d;
            tmo_q    <= tmo_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                {n0_q, n1_q} <= mem_q[rd_ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_noise0, in_noise1};
    end
endmodule

// File: tb/tb_gan_batch_sched.sv
// tb_gan_batch_sched: directed and randomized checks of gan_batch_sched against a queue-based
// model of the pending noise pairs and the Q1.15 "real" threshold rule.
module tb_gan_batch_sched;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, eng_done = 1'b0, out_ready = 1'b0;
    logic [15:0] in_noise0 = '0, in_noise1 = '0, eng_prob = '0;
    logic        in_ready, eng_start, out_valid, out_real, out_timeout, busy;
    logic [15:0] eng_noise0, eng_noise1, out_prob;
    logic [2:0]  count;
    int          checks = 0, errors = 0, starts = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    gan_batch_sched dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_noise0(in_noise0), .in_noise1(in_noise1), .eng_start(eng_start),
        .eng_noise0(eng_noise0), .eng_noise1(eng_noise1), .eng_done(eng_done),
        .eng_prob(eng_prob), .out_valid(out_valid), .out_ready(out_ready),
        .out_prob(out_prob), .out_real(out_real), .out_timeout(out_timeout),
        .busy(busy), .count(count)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_one(input logic [15:0] a, input logic [15:0] b);
        logic acc;
        acc = q.size() < 4;
        chk("push_ready", in_ready, acc);
        in_valid = 1'b1; in_noise0 = a; in_noise1 = b;
        tick();
        in_valid = 1'b0;
        if (acc) q.push_back({a, b});
    endtask

    task automatic wait_start(input int lim);
        int n = 0;
        logic [31:0] e;
        while (!eng_start && n < lim) begin
            tick();
            n++;
        end
        chk("start_seen", eng_start, 1);
        e = '0;
        if (q.size() != 0) e = q.pop_front();
        chk("start_noise", {eng_noise0, eng_noise1}, e);
        chk("start_busy", busy, 1);
        starts++;
        tick();
        chk("start_pulse", eng_start, 0);
    endtask

    task automatic finish_result(input logic [15:0] p, input int hold_n);
        eng_prob = p; eng_done = 1'b1;
        tick();
        eng_done = 1'b0;
        chk("res_valid", out_valid, 1);
        chk("res_prob", out_prob, p);
        chk("res_real", out_real, $signed(p) > 16384);
        chk("res_timeout", out_timeout, 0);
        for (int i = 0; i < hold_n; i++) begin
            eng_done = 1'b1; eng_prob = ~p;
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_prob", out_prob, p);
            chk("hold_no_start", eng_start, 0);
        end
        eng_done = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
    endtask

    task automatic run_one(input logic [15:0] p, input int wait_n, input int hold_n);
        push_one(16'($urandom), 16'($urandom));
        wait_start(1);
        for (int i = 0; i < wait_n; i++) begin
            tick();
            chk("wait_no_valid", out_valid, 0);
        end
        finish_result(p, hold_n);
    endtask

    initial begin
        logic [15:0] tbl [6];
        logic [15:0] a, b;
        logic acc;
        int n, s0;
        tbl = '{16'h4000, 16'h8000, 16'h4001, 16'h7fff, 16'h0000, 16'hc000};
        tick();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_eng_start", eng_start, 0);
        chk("rst_noise", {eng_noise0, eng_noise1}, 0);
        chk("rst_result", {out_prob, out_real, out_timeout}, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_no_start", eng_start, 0);
        end
        // single push into idle, one-cycle latencies
        push_one(16'h4000, 16'h4000);
        chk("t1_count", count, 1);
        chk("t1_no_start_yet", eng_start, 0);
        wait_start(1);
        finish_result(16'h6000, 0);
        chk("t1_idle_busy", busy, 0);
        // threshold boundaries
        foreach (tbl[i]) run_one(tbl[i], $urandom_range(0, 5), 0);
        for (int i = 0; i < 6; i++) run_one(16'($urandom), $urandom_range(0, 5), $urandom_range(0, 3));
        // fill while the engine is stalled, then drain in order
        s0 = starts;
        push_one(16'($urandom), 16'($urandom));
        wait_start(1);
        for (int i = 0; i < 5; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            acc = q.size() < 4;
            in_valid = 1'b1; in_noise0 = a; in_noise1 = b;
            chk("fill_ready", in_ready, acc);
            tick();
            if (acc) q.push_back({a, b});
        end
        in_valid = 1'b0;
        chk("fill_count", count, 4);
        chk("fill_full", in_ready, 0);
        for (int k = 0; k < 5; k++) begin
            finish_result(16'($urandom), (k == 0) ? 10 : 0);
            if (q.size() != 0) wait_start(1);
        end
        chk("drain_starts", starts - s0, 5);
        chk("drain_empty", count, 0);
        // timeout after TIMEOUT_CYC wait cycles
        push_one(16'h1234, 16'h5678);
        wait_start(1);
        n = 0;
        while (!out_valid && n < 400) begin
            tick();
            n++;
        end
        chk("tmo_cycles", n, 255);
        chk("tmo_flag", out_timeout, 1);
        chk("tmo_prob", out_prob, 0);
        chk("tmo_real", out_real, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("tmo_release", out_valid, 0);
        // eng_done wins on the terminal wait cycle
        push_one(16'h0bad, 16'hcafe);
        wait_start(1);
        repeat (254) tick();
        chk("prio_not_yet", out_valid, 0);
        finish_result(16'h5000, 0);
        // async reset mid-WAIT with two pairs queued
        push_one(16'($urandom), 16'($urandom));
        wait_start(1);
        push_one(16'($urandom), 16'($urandom));
        push_one(16'($urandom), 16'($urandom));
        chk("rstw_count2", count, 2);
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("rstw_count", count, 0);
        chk("rstw_valid", out_valid, 0);
        chk("rstw_busy", busy, 0);
        chk("rstw_ready", in_ready, 1);
        chk("rstw_noise", {eng_noise0, eng_noise1}, 0);
        tick();
        rst_n = 1'b1;
        eng_done = 1'b1; eng_prob = 16'h7000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("late_done_valid", out_valid, 0);
            chk("late_done_start", eng_start, 0);
            chk("late_done_busy", busy, 0);
        end
        eng_done = 1'b0;
        run_one(16'h2000, 2, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
